uart_tx_cfg: RTL and testbench

Configurable UART transmitter. It replaces the fixed 8N1 transmitter with one whose data width, parity and stop-bit count are set by parameters, and adds a small transmit FIFO so the CPU-side bus can queue several characters without polling. It sits between the memory-mapped UART register block and the board serial pin, and sends frames back-to-back while the FIFO holds data.

---
 rtl/uart_tx_cfg.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a small transmit FIFO.
//
// The data width, parity mode, stop-bit count and line polarity are set by
// parameters. Characters written while the FIFO has room are queued. Frames
// are sent back-to-back for as long as the FIFO holds data.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (aborts any frame, flushes FIFO)
//   we        in   write strobe; din is queued when we=1 and full=0
//   din       in   character to queue (DATA_BITS wide)
//   full      out  FIFO holds FIFO_DEPTH entries
//   empty     out  FIFO empty and no frame in progress
//   level     out  queued entries, excluding the frame being shifted
//   done      out  one-cycle pulse after the last stop bit of a frame
//   overflow  out  one-cycle pulse after a write dropped because full=1
//   tx        out  serial line (registered; INVERT applied after the register)
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 1000,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int INVERT       = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [DATA_BITS-1:0]              din,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              done,
    output logic                              overflow,
    output logic                              tx
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              LW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0]     BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0]   DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a character: even = XOR of the data, odd = its inverse.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level_nx;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    state_t               state;
    state_t               state_nx;
    logic [15:0]          cnt;
    logic [15:0]          cnt_nx;
    logic [3:0]           idx;
    logic [3:0]           idx_nx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nx;
    logic                 par_bit;
    logic                 par_bit_nx;
    logic                 tx_line;
    logic                 tx_line_nx;
    logic                 done_nx;
    logic                 bit_end;

    // A write while full is dropped even if the same edge pops an entry.
    assign push    = we && !full;
    assign head    = mem[rd_ptr];
    assign bit_end = (cnt == BIT_LAST);

    always_comb begin
        level_nx = level;
        if (push && !pop) begin
            level_nx = level + LW'(1);
        end else if (pop && !push) begin
            level_nx = level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_nx;
            full     <= (level_nx == DEPTH_L);
            // Drained means nothing queued and the FSM heading back to idle.
            empty    <= (level_nx == '0) && (state_nx == ST_IDLE);
            overflow <= we && full;
        end
    end

    // FIFO storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        shreg_nx   = shreg;
        par_bit_nx = par_bit;
        done_nx    = 1'b0;
        pop        = 1'b0;
        tx_line_nx = 1'b1;

        case (state)
            ST_IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    shreg_nx   = head;
                    par_bit_nx = parity_of(head);
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    state_nx   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = ST_DATA;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    if (idx == DATA_LAST) begin
                        idx_nx   = '0;
                        state_nx = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_nx   = idx + 4'd1;
                        shreg_nx = shreg >> 1;
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = ST_STOP;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    if (idx == STOP_LAST) begin
                        done_nx = 1'b1;
                        idx_nx  = '0;
                        // Chain straight into the next start bit when data waits.
                        if (level != '0) begin
                            pop        = 1'b1;
                            shreg_nx   = head;
                            par_bit_nx = parity_of(head);
                            state_nx   = ST_START;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase

        // The line register follows the state being entered, so tx changes on
        // the same edge as the state.
        case (state_nx)
            ST_START:  tx_line_nx = 1'b0;
            ST_DATA:   tx_line_nx = shreg_nx[0];
            ST_PARITY: tx_line_nx = par_bit_nx;
            default:   tx_line_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            tx_line <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            tx_line <= tx_line_nx;
            done    <= done_nx;
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= shreg_nx;
        par_bit <= par_bit_nx;
    end

    assign tx = (INVERT != 0) ? ~tx_line : tx_line;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg. Four instances share clock and reset:
// u0 default 8N1, u1 7 data bits even parity 2 stop, u2 same with odd parity,
// u3 default with inverted line. u0 and u3 share their write inputs.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we8 = 1'b0;
    logic [7:0] din8 = 8'h00;
    logic       we7 = 1'b0;
    logic [6:0] din7 = 7'h00;

    logic       full0, empty0, done0, ovf0, tx0;
    logic [2:0] level0;
    logic       full1, empty1, done1, ovf1, tx1;
    logic [2:0] level1;
    logic       full2, empty2, done2, ovf2, tx2;
    logic [2:0] level2;
    logic       full3, empty3, done3, ovf3, tx3;
    logic [2:0] level3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we8), .din(din8), .full(full0), .empty(empty0),
        .level(level0), .done(done0), .overflow(ovf0), .tx(tx0));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we7), .din(din7), .full(full1), .empty(empty1),
        .level(level1), .done(done1), .overflow(ovf1), .tx(tx1));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we7), .din(din7), .full(full2), .empty(empty2),
        .level(level2), .done(done2), .overflow(ovf2), .tx(tx2));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .INVERT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .we(we8), .din(din8), .full(full3), .empty(empty3),
        .level(level3), .done(done3), .overflow(ovf3), .tx(tx3));

    // Expected 8N1 line level at bit position pos (0 = start, 9 = stop).
    function automatic logic exp_8n1(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        nvec++;
        if (tx0 !== 1'b1 || empty0 !== 1'b1 || full0 !== 1'b0 || level0 !== 3'd0 ||
            done0 !== 1'b0 || ovf0 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_u0: tx=%b empty=%b full=%b level=%0d done=%b ovf=%b, want 1 1 0 0 0 0",
                     tx0, empty0, full0, level0, done0, ovf0);
        end
        nvec++;
        if (tx3 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_invert_tx: got %b want 0", tx3);
        end
        nvec++;
        if (tx1 !== 1'b1 || empty1 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_u1: tx=%b empty=%b want 1 1", tx1, empty1);
        end
        rst_n = 1'b1;
        repeat (3) step();
        nvec++;
        if (tx0 !== 1'b1 || empty0 !== 1'b1 || done0 !== 1'b0) begin
            nerr++;
            $display("FAIL idle_after_reset: tx=%b empty=%b done=%b want 1 1 0", tx0, empty0, done0);
        end
    endtask

    // 0xA5 on 8N1 plus the inverted copy on u3.
    task automatic test_basic();
        logic e;
        we8 = 1'b1; din8 = 8'hA5;
        step();                                   // E0: write accepted
        we8 = 1'b0;
        nvec++;
        if (level0 !== 3'd1 || empty0 !== 1'b0 || tx0 !== 1'b1) begin
            nerr++;
            $display("FAIL basic_after_write: level=%0d empty=%b tx=%b want 1 0 1", level0, empty0, tx0);
        end
        for (int c = 0; c < 40; c++) begin
            step();                               // E1+c
            e = exp_8n1(8'hA5, c / 4);
            nvec++;
            if (tx0 !== e) begin
                nerr++;
                $display("FAIL basic_tx c=%0d: got %b want %b", c, tx0, e);
            end
            nvec++;
            if (tx3 !== ~e) begin
                nerr++;
                $display("FAIL invert_tx c=%0d: got %b want %b", c, tx3, ~e);
            end
            nvec++;
            if (done0 !== 1'b0 || empty0 !== 1'b0) begin
                nerr++;
                $display("FAIL basic_inframe c=%0d: done=%b empty=%b want 0 0", c, done0, empty0);
            end
        end
        step();                                   // E41
        nvec++;
        if (done0 !== 1'b1 || empty0 !== 1'b1 || tx0 !== 1'b1 || tx3 !== 1'b0) begin
            nerr++;
            $display("FAIL basic_end: done=%b empty=%b tx=%b tx_inv=%b want 1 1 1 0",
                     done0, empty0, tx0, tx3);
        end
        step();
        nvec++;
        if (done0 !== 1'b0) begin
            nerr++;
            $display("FAIL basic_done_width: got %b want 0", done0);
        end
    endtask

    // 0x55 on 7 data bits: four ones -> even parity 0, odd parity 1.
    task automatic test_parity();
        logic [10:0] seq_even;
        logic [10:0] seq_odd;
        // index = bit position: start, d0..d6, parity, stop, stop
        seq_even = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        seq_odd  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        we7 = 1'b1; din7 = 7'h55;
        step();
        we7 = 1'b0;
        for (int c = 0; c < 44; c++) begin
            step();
            nvec++;
            if (tx1 !== seq_even[c/4]) begin
                nerr++;
                $display("FAIL even_tx c=%0d: got %b want %b", c, tx1, seq_even[c/4]);
            end
            nvec++;
            if (tx2 !== seq_odd[c/4]) begin
                nerr++;
                $display("FAIL odd_tx c=%0d: got %b want %b", c, tx2, seq_odd[c/4]);
            end
        end
        step();
        nvec++;
        if (done1 !== 1'b1 || done2 !== 1'b1 || empty1 !== 1'b1 || empty2 !== 1'b1) begin
            nerr++;
            $display("FAIL parity_end: done=%b%b empty=%b%b want 11 11", done1, done2, empty1, empty2);
        end
    endtask

    // Five queued writes, one overflow, five frames with no idle gap.
    task automatic test_fifo_burst();
        logic       e;
        logic [7:0] b;
        int         lvl;
        we8 = 1'b1; din8 = 8'h01;
        step();                                   // W1
        nvec++;
        if (level0 !== 3'd1) begin
            nerr++;
            $display("FAIL burst_w1_level: got %0d want 1", level0);
        end
        for (int c = 0; c <= 200; c++) begin
            we8  = (c < 5);
            din8 = 8'(c + 2);                     // c=4 is the 6th write (0x06), dropped
            step();                               // edge W(c+2); frame 1 starts at c=0
            if (c >= 200) begin
                e = 1'b1;
            end else begin
                b = 8'(c / 40 + 1);
                e = exp_8n1(b, (c % 40) / 4);
            end
            nvec++;
            if (tx0 !== e) begin
                nerr++;
                $display("FAIL burst_tx c=%0d: got %b want %b", c, tx0, e);
            end
            lvl = (c < 3) ? c + 1 : 4 - c / 40;
            if (lvl < 0) lvl = 0;
            nvec++;
            if (level0 !== 3'(lvl)) begin
                nerr++;
                $display("FAIL burst_level c=%0d: got %0d want %0d", c, level0, lvl);
            end
            nvec++;
            if (done0 !== ((c % 40 == 0) && (c >= 40))) begin
                nerr++;
                $display("FAIL burst_done c=%0d: got %b", c, done0);
            end
            nvec++;
            if (ovf0 !== (c == 4)) begin
                nerr++;
                $display("FAIL burst_overflow c=%0d: got %b want %b", c, ovf0, (c == 4));
            end
            nvec++;
            if (full0 !== (c >= 3 && c < 40)) begin
                nerr++;
                $display("FAIL burst_full c=%0d: got %b want %b", c, full0, (c >= 3 && c < 40));
            end
        end
        nvec++;
        if (empty0 !== 1'b1) begin
            nerr++;
            $display("FAIL burst_empty_end: got %b want 1", empty0);
        end
    endtask

    // Write landing on the pop edge while level=1 keeps level at 1 and order.
    task automatic test_same_edge();
        logic       e;
        logic [7:0] b;
        we8 = 1'b1; din8 = 8'h3C;
        step();                                   // E0
        nvec++;
        if (level0 !== 3'd1) begin
            nerr++;
            $display("FAIL same_edge_pre: level=%0d want 1", level0);
        end
        din8 = 8'hC3;
        for (int c = 0; c <= 80; c++) begin
            we8 = (c == 0);
            step();                               // E1+c; pop and push together at c=0
            if (c == 0) begin
                nvec++;
                if (level0 !== 3'd1) begin
                    nerr++;
                    $display("FAIL same_edge_level: got %0d want 1", level0);
                end
            end
            if (c >= 80) begin
                e = 1'b1;
            end else begin
                b = (c < 40) ? 8'h3C : 8'hC3;
                e = exp_8n1(b, (c % 40) / 4);
            end
            nvec++;
            if (tx0 !== e) begin
                nerr++;
                $display("FAIL same_edge_tx c=%0d: got %b want %b", c, tx0, e);
            end
        end
        nvec++;
        if (done0 !== 1'b1 || empty0 !== 1'b1 || level0 !== 3'd0) begin
            nerr++;
            $display("FAIL same_edge_end: done=%b empty=%b level=%0d want 1 1 0", done0, empty0, level0);
        end
        we8 = 1'b0;
    endtask

    // Asynchronous reset in a data bit with three entries queued.
    task automatic test_reset_midframe();
        we8 = 1'b1; din8 = 8'h00;
        repeat (4) step();                        // E0..E3
        we8 = 1'b0;
        repeat (4) step();                        // E7: inside data bit 0
        nvec++;
        if (tx0 !== 1'b0 || level0 !== 3'd3) begin
            nerr++;
            $display("FAIL midframe_pre: tx=%b level=%0d want 0 3", tx0, level0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (tx0 !== 1'b1 || tx3 !== 1'b0 || level0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin
            nerr++;
            $display("FAIL midframe_async: tx=%b tx_inv=%b level=%0d empty=%b full=%b want 1 0 0 1 0",
                     tx0, tx3, level0, empty0, full0);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            nvec++;
            if (tx0 !== 1'b1 || done0 !== 1'b0 || empty0 !== 1'b1 || level0 !== 3'd0) begin
                nerr++;
                $display("FAIL midframe_after c=%0d: tx=%b done=%b empty=%b level=%0d want 1 0 1 0",
                         c, tx0, done0, empty0, level0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_fifo_burst();
        test_same_edge();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
